vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
//   Shares one single-port frame-buffer RAM between the camera writer and the VGA display reader.
//   Prefetches pixels in raster order into a small show-ahead FIFO feeding the display stage (pix_read/pix_data).
//   Grants camera writes in the remaining memory slots.
//   Display reads are urgent and must never be starved by camera traffic.
// PARAMETERS
//   ADDR_W      19   frame-buffer address width
//   DATA_W      3    pixel width (RGB 1:1:1)
//   NUM_PIX     307200  pixels per frame (640x480); last read address NUM_PIX-1
//   FIFO_DEPTH  16   prefetch FIFO entries (power of 2)
//   FIFO_LOW    8    urgency threshold; read beats camera when level+inflight < FIFO_LOW
// PORTS
//   clk_25      in   1       pixel clock, all logic on rising edge
//   rst_n       in   1       asynchronous active-low reset
//   frame_start in   1       1-cycle pulse in vertical blank: restart reader at address 0
//   pix_read    in   1       display consumes one pixel this cycle
//   pix_data    out  DATA_W  FIFO head pixel (show-ahead); 0 when FIFO empty
//   underflow   out  1       sticky: pix_read seen with FIFO empty
//   cam_req     in   1       camera write request, held until cam_ack
//   cam_addr    in   ADDR_W  write address, stable while cam_req
//   cam_data    in   DATA_W  write pixel, stable while cam_req
//   cam_ack     out  1       1-cycle pulse: request issued to RAM
//   mem_en      out  1       RAM access strobe (registered)
//   mem_we      out  1       1 = write, 0 = read (registered)
//   mem_addr    out  ADDR_W  RAM address (registered)
//   mem_wdata   out  DATA_W  RAM write data (registered)
//   mem_rdata   in   DATA_W  RAM read data, valid the cycle after mem_en & ~mem_we
// BEHAVIOUR
// - Reset (rst_n=0, async): FIFO empty, rd_addr=0, inflight=0, done=0.
//   All outputs 0: mem_*, cam_ack, underflow, pix_data.
// - Per-cycle grant decision, registered onto mem_* and cam_ack at the next edge.
//   Exactly one of READ/WRITE/IDLE is granted per cycle.
//     rd_ok  = ~done & (level + inflight < FIFO_DEPTH)
//     urgent = level + inflight < FIFO_LOW
//     wr_ok  = cam_req & ~cam_ack   (no double grant while ack is high)
//     priority: rd_ok&urgent -> READ; else wr_ok -> WRITE; else rd_ok -> READ; else IDLE.
// - READ: mem_en=1, mem_we=0, mem_addr=rd_addr; rd_addr++; inflight++.
//   At rd_addr==NUM_PIX-1 set done (no wrap); reads stop until frame_start.
// - WRITE: mem_en=1, mem_we=1, mem_addr=cam_addr, mem_wdata=cam_data, cam_ack=1 in the same cycle.
//   Camera may drop or change cam_req the cycle after cam_ack.
// - Return: cycle after a READ beat, mem_rdata is pushed into the FIFO and inflight--.
//   Read latency: grant -> FIFO entry = 2 edges.
// - inflight is 0..2; level+inflight never exceeds FIFO_DEPTH, so the FIFO cannot overflow.
// - pix_data = FIFO head when level>0, else 0 (black). pix_read & level>0 pops.
//   Simultaneous push+pop keeps level constant.
// - pix_read & level==0: no pop, pix_data=0, underflow<=1 (sticky).
// - frame_start (synchronous, overrides the grant for that cycle):
//     FIFO flushed, rd_addr=0, done=0, underflow=0, no new grant that cycle.
//     Returns from reads already in flight are discarded (counted, not pushed).
//     A write whose cam_ack is already issued completes normally.
//     A pending cam_req stays pending and is granted later.
// - frame_start coincident with pix_read: flush wins, no pop, no underflow set.
// - Reset mid-access: mem_en drops immediately, no ack.
//   Camera must re-request after reset.
// TESTING
// 1. Reset, frame_start, no cam_req, no pix_read.
//    -> READs at addr 0..15 on consecutive cycles, then IDLE; level=16, pix_data=mem[0].
// 2. FIFO full, then pix_read held for 40 cycles with RAM pattern data=addr[2:0].
//    -> pix_data sequence 0,1,..7,0.. with no gaps; underflow stays 0.
// 3. cam_req held continuously (addr 0x100, data 3'b101) while display streams.
//    -> reads win when level+inflight<8; cam_ack within 16 cycles; exactly one
//       mem_we pulse per ack, mem_addr=0x100, mem_wdata=3'b101.
// 4. pix_read with FIFO empty straight after frame_start.
//    -> pix_data=0, underflow=1; underflow cleared by the next frame_start.
// 5. frame_start with 2 reads in flight and level=5.
//    -> next cycle level=0; stale returns dropped; next read addr=0.
// 6. Stream NUM_PIX reads -> last mem_addr=NUM_PIX-1, no further reads until frame_start;
//    rst_n pulsed mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/vga_fb_arbiter_if.sv
// rtl/vga_fb_arbiter_if.sv - display, camera and frame-buffer RAM signals of the arbiter
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 3
);
  logic              frame_start;
  logic              pix_read;
  logic [DATA_W-1:0] pix_data;
  logic              underflow;
  logic              cam_req;
  logic [ADDR_W-1:0] cam_addr;
  logic [DATA_W-1:0] cam_data;
  logic              cam_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  frame_start, pix_read, cam_req, cam_addr, cam_data, mem_rdata,
    output pix_data, underflow, cam_ack, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output frame_start, pix_read, cam_req, cam_addr, cam_data, mem_rdata,
    input  pix_data, underflow, cam_ack, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port frame-buffer arbiter: display prefetch FIFO vs camera writes
module vga_fb_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 3,
  parameter int NUM_PIX    = 307200,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_LOW   = 8
) (
  input  logic            clk_25,
  input  logic            rst_n,
  vga_fb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int SUM_W = LVL_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

  typedef enum logic [1:0] {GNT_IDLE, GNT_READ, GNT_WRITE} gnt_e;

  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [1:0]        inflight_q, inflight_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              done_q, done_d;
  logic              underflow_q, underflow_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cam_ack_q, cam_ack_d;
  logic              ret_vld_q, ret_vld_d, ret_live_q, ret_live_d;

  gnt_e              gnt;
  logic [SUM_W-1:0]  occ;
  logic              rd_ok, urgent, wr_ok, push, pop;

  // occ counts FIFO entries plus reads whose data has not landed yet
  always_comb begin
    occ    = SUM_W'(level_q) + SUM_W'(inflight_q);
    rd_ok  = ~done_q & (occ < SUM_W'(FIFO_DEPTH));
    urgent = occ < SUM_W'(FIFO_LOW);
    wr_ok  = bus.cam_req & ~cam_ack_q;
    push   = ret_vld_q & ret_live_q & ~bus.frame_start;
    pop    = bus.pix_read & (level_q != '0) & ~bus.frame_start;
    gnt    = GNT_IDLE;
    if (!bus.frame_start) begin
      if (rd_ok && urgent)  gnt = GNT_READ;
      else if (wr_ok)       gnt = GNT_WRITE;
      else if (rd_ok)       gnt = GNT_READ;
    end
  end

  always_comb begin
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
    inflight_d  = inflight_q + {1'b0, (gnt == GNT_READ)} - {1'b0, ret_vld_q};
    rd_addr_d   = rd_addr_q;
    done_d      = done_q;
    underflow_d = underflow_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cam_ack_d   = 1'b0;
    ret_vld_d   = mem_en_q & ~mem_we_q;
    // a beat on the RAM bus during a flush belongs to the old frame
    ret_live_d  = ~bus.frame_start;

    case (gnt)
      GNT_READ: begin
        mem_en_d   = 1'b1;
        mem_addr_d = rd_addr_q;
        if (rd_addr_q == LAST_ADDR) done_d = 1'b1;
        else                        rd_addr_d = rd_addr_q + ADDR_W'(1);
      end
      GNT_WRITE: begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = bus.cam_addr;
        mem_wdata_d = bus.cam_data;
        cam_ack_d   = 1'b1;
      end
      default: ;
    endcase

    if (push) begin
      fifo_d[wr_ptr_q] = bus.mem_rdata;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (bus.frame_start) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      rd_addr_d   = '0;
      done_d      = 1'b0;
      underflow_d = 1'b0;
    end else if (bus.pix_read && level_q == '0) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      inflight_q  <= '0;
      rd_addr_q   <= '0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cam_ack_q   <= 1'b0;
      ret_vld_q   <= 1'b0;
      ret_live_q  <= 1'b0;
    end else begin
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      inflight_q  <= inflight_d;
      rd_addr_q   <= rd_addr_d;
      done_q      <= done_d;
      underflow_q <= underflow_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cam_ack_q   <= cam_ack_d;
      ret_vld_q   <= ret_vld_d;
      ret_live_q  <= ret_live_d;
    end
  end

  assign bus.pix_data  = (level_q != '0) ? fifo_q[rd_ptr_q] : '0;
  assign bus.underflow = underflow_q;
  assign bus.cam_ack   = cam_ack_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;
  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 3;
  localparam int NUM_PIX = 96;

  logic clk_25 = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_25 = ~clk_25;

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  vga_fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_PIX(NUM_PIX), .FIFO_DEPTH(16), .FIFO_LOW(8)
  ) dut (
    .clk_25(clk_25),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int pop_idx = 0;

  // RAM: frame region holds addr[2:0]; camera writes land at 0x100..0x1FF
  logic [DATA_W-1:0] wram [0:255];
  always @(posedge clk_25) begin
    if (bus.mem_en) begin
      if (bus.mem_we) wram[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else if (bus.mem_addr < 19'h100) bus.mem_rdata <= bus.mem_addr[2:0];
      else bus.mem_rdata <= wram[bus.mem_addr[7:0]];
    end
  end

  int cyc = 0;
  int we_cnt = 0;
  int ack_cnt = 0;
  logic [ADDR_W-1:0] rd_q[$];
  int rd_cyc[$];
  always @(posedge clk_25) begin
    #1;
    cyc++;
    if (bus.mem_en && !bus.mem_we) begin
      rd_q.push_back(bus.mem_addr);
      rd_cyc.push_back(cyc);
    end
    if (bus.mem_en && bus.mem_we) we_cnt++;
    if (bus.cam_ack) ack_cnt++;
  end

  task automatic tick();
    @(negedge clk_25);
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    rd_q.delete();
    rd_cyc.delete();
    pop_idx = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cam_req = 1'b1;
    bus.cam_addr = 19'h155;
    bus.cam_data = 3'b110;
    bus.pix_read = 1'b1;
    repeat (3) tick();
    total++;
    if ({bus.mem_en, bus.mem_we, bus.cam_ack, bus.underflow} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0000", {bus.mem_en, bus.mem_we, bus.cam_ack, bus.underflow});
    end
    total++;
    if (bus.mem_addr !== '0) begin bad++; $display("FAIL reset_mem_addr got=%0h exp=0", bus.mem_addr); end
    total++;
    if (bus.mem_wdata !== '0) begin bad++; $display("FAIL reset_mem_wdata got=%0d exp=0", bus.mem_wdata); end
    total++;
    if (bus.pix_data !== '0) begin bad++; $display("FAIL reset_pix_data got=%0d exp=0", bus.pix_data); end
    bus.cam_req = 1'b0;
    bus.pix_read = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    int n;
    start_frame();
    repeat (30) tick();
    total++;
    if (rd_q.size() != 16) begin bad++; $display("FAIL fill_read_count got=%0d exp=16", rd_q.size()); end
    n = (rd_q.size() < 16) ? rd_q.size() : 16;
    for (int i = 0; i < n; i++) begin
      total++;
      if (rd_q[i] !== ADDR_W'(i)) begin bad++; $display("FAIL fill_addr[%0d] got=%0d exp=%0d", i, rd_q[i], i); end
      total++;
      if (rd_cyc[i] != rd_cyc[0] + i) begin
        bad++; $display("FAIL fill_consecutive[%0d] got=%0d exp=%0d", i, rd_cyc[i], rd_cyc[0] + i);
      end
    end
    total++;
    if (bus.pix_data !== 3'd0) begin bad++; $display("FAIL fill_head got=%0d exp=0", bus.pix_data); end
  endtask

  task automatic test_stream();
    logic [2:0] exp;
    for (int i = 0; i < 40; i++) begin
      bus.pix_read = 1'b1;
      exp = pop_idx[2:0];
      total++;
      if (bus.pix_data !== exp) begin bad++; $display("FAIL stream_pix[%0d] got=%0d exp=%0d", pop_idx, bus.pix_data, exp); end
      pop_idx++;
      tick();
    end
    bus.pix_read = 1'b0;
    tick();
    total++;
    if (bus.underflow !== 1'b0) begin bad++; $display("FAIL stream_underflow got=%0d exp=0", bus.underflow); end
    for (int i = 0; i < rd_q.size(); i++) begin
      total++;
      if (rd_q[i] !== ADDR_W'(i)) begin bad++; $display("FAIL stream_addr[%0d] got=%0d exp=%0d", i, rd_q[i], i); end
    end
  endtask

  task automatic test_cam();
    int we0, ack0, got;
    logic rd;
    logic [2:0] exp;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    start_frame();
    repeat (20) tick();
    we0 = we_cnt;
    ack0 = ack_cnt;
    for (int r = 0; r < 4; r++) begin
      a = (r == 0) ? 19'h100 : ADDR_W'(19'h100 + $urandom_range(1, 255));
      d = (r == 0) ? 3'b101 : DATA_W'($urandom_range(0, 7));
      bus.cam_req = 1'b1;
      bus.cam_addr = a;
      bus.cam_data = d;
      got = 0;
      for (int c = 0; c < 16 && got == 0; c++) begin
        rd = ($urandom_range(0, 2) == 0);
        bus.pix_read = rd;
        if (rd) begin
          exp = pop_idx[2:0];
          total++;
          if (bus.pix_data !== exp) begin bad++; $display("FAIL cam_pix[%0d] got=%0d exp=%0d", pop_idx, bus.pix_data, exp); end
          pop_idx++;
        end
        tick();
        if (bus.cam_ack) begin
          got = 1;
          total++;
          if ({bus.mem_en, bus.mem_we} !== 2'b11) begin bad++; $display("FAIL cam_we[%0d] got=%b exp=11", r, {bus.mem_en, bus.mem_we}); end
          total++;
          if (bus.mem_addr !== a) begin bad++; $display("FAIL cam_addr[%0d] got=%0h exp=%0h", r, bus.mem_addr, a); end
          total++;
          if (bus.mem_wdata !== d) begin bad++; $display("FAIL cam_wdata[%0d] got=%0d exp=%0d", r, bus.mem_wdata, d); end
        end
      end
      total++;
      if (got == 0) begin bad++; $display("FAIL cam_ack_timeout[%0d] got=none exp=ack within 16", r); end
    end
    bus.cam_req = 1'b0;
    bus.pix_read = 1'b0;
    repeat (3) tick();
    total++;
    if (we_cnt - we0 != 4) begin bad++; $display("FAIL cam_we_pulses got=%0d exp=4", we_cnt - we0); end
    total++;
    if (ack_cnt - ack0 != 4) begin bad++; $display("FAIL cam_ack_pulses got=%0d exp=4", ack_cnt - ack0); end
    total++;
    if (bus.underflow !== 1'b0) begin bad++; $display("FAIL cam_underflow got=%0d exp=0", bus.underflow); end
  endtask

  task automatic test_underflow();
    logic [2:0] exp;
    start_frame();
    bus.pix_read = 1'b1;
    total++;
    if (bus.pix_data !== '0) begin bad++; $display("FAIL uf_pix_black got=%0d exp=0", bus.pix_data); end
    tick();
    bus.pix_read = 1'b0;
    total++;
    if (bus.underflow !== 1'b1) begin bad++; $display("FAIL uf_set got=%0d exp=1", bus.underflow); end
    repeat (20) tick();
    total++;
    if (bus.underflow !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%0d exp=1", bus.underflow); end
    start_frame();
    total++;
    if (bus.underflow !== 1'b0) begin bad++; $display("FAIL uf_clear got=%0d exp=0", bus.underflow); end
    bus.frame_start = 1'b1;
    bus.pix_read = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    bus.pix_read = 1'b0;
    rd_q.delete();
    rd_cyc.delete();
    pop_idx = 0;
    total++;
    if (bus.underflow !== 1'b0) begin bad++; $display("FAIL uf_flush_wins got=%0d exp=0", bus.underflow); end
    repeat (25) tick();
    for (int i = 0; i < 10; i++) begin
      bus.pix_read = 1'b1;
      exp = pop_idx[2:0];
      total++;
      if (bus.pix_data !== exp) begin bad++; $display("FAIL uf_after_pix[%0d] got=%0d exp=%0d", pop_idx, bus.pix_data, exp); end
      pop_idx++;
      tick();
    end
    bus.pix_read = 1'b0;
  endtask

  task automatic test_flush_inflight();
    int k;
    logic [2:0] exp;
    for (int t = 0; t < 6; t++) begin
      start_frame();
      repeat (22) tick();
      k = $urandom_range(3, 20);
      for (int i = 0; i < k; i++) begin
        bus.pix_read = 1'b1;
        pop_idx++;
        tick();
      end
      bus.pix_read = 1'b0;
      start_frame();
      total++;
      if (bus.pix_data !== '0) begin bad++; $display("FAIL flush_empty_pix[%0d] got=%0d exp=0", t, bus.pix_data); end
      bus.pix_read = 1'b1;
      tick();
      bus.pix_read = 1'b0;
      total++;
      if (bus.underflow !== 1'b1) begin bad++; $display("FAIL flush_level_zero[%0d] got=%0d exp=1", t, bus.underflow); end
      repeat (20) tick();
      total++;
      if (rd_q.size() == 0 || rd_q[0] !== '0) begin
        bad++; $display("FAIL flush_first_addr[%0d] got=%0d exp=0", t, (rd_q.size() == 0) ? -1 : int'(rd_q[0]));
      end
      for (int i = 0; i < 12; i++) begin
        bus.pix_read = 1'b1;
        exp = pop_idx[2:0];
        total++;
        if (bus.pix_data !== exp) begin bad++; $display("FAIL flush_pix[%0d.%0d] got=%0d exp=%0d", t, pop_idx, bus.pix_data, exp); end
        pop_idx++;
        tick();
      end
      bus.pix_read = 1'b0;
    end
  endtask

  task automatic test_done_and_reset();
    logic [2:0] exp;
    start_frame();
    repeat (20) tick();
    for (int c = 0; c < 400 && pop_idx < NUM_PIX; c++) begin
      bus.pix_read = 1'b1;
      exp = pop_idx[2:0];
      total++;
      if (bus.pix_data !== exp) begin bad++; $display("FAIL done_pix[%0d] got=%0d exp=%0d", pop_idx, bus.pix_data, exp); end
      pop_idx++;
      tick();
    end
    bus.pix_read = 1'b0;
    repeat (20) tick();
    total++;
    if (rd_q.size() != NUM_PIX) begin bad++; $display("FAIL done_read_count got=%0d exp=%0d", rd_q.size(), NUM_PIX); end
    total++;
    if (rd_q.size() == 0 || rd_q[rd_q.size()-1] !== ADDR_W'(NUM_PIX - 1)) begin
      bad++; $display("FAIL done_last_addr got=%0d exp=%0d", (rd_q.size() == 0) ? -1 : int'(rd_q[rd_q.size()-1]), NUM_PIX - 1);
    end
    total++;
    if (bus.underflow !== 1'b0) begin bad++; $display("FAIL done_underflow got=%0d exp=0", bus.underflow); end
    total++;
    if (bus.pix_data !== '0) begin bad++; $display("FAIL done_drained got=%0d exp=0", bus.pix_data); end

    start_frame();
    repeat (5) tick();
    bus.pix_read = 1'b1;
    bus.cam_req = 1'b1;
    bus.cam_addr = 19'h180;
    bus.cam_data = 3'b111;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.mem_en, bus.mem_we, bus.cam_ack, bus.underflow} !== 4'b0) begin
      bad++; $display("FAIL async_rst_ctrl got=%b exp=0000", {bus.mem_en, bus.mem_we, bus.cam_ack, bus.underflow});
    end
    total++;
    if (bus.mem_addr !== '0) begin bad++; $display("FAIL async_rst_addr got=%0h exp=0", bus.mem_addr); end
    total++;
    if (bus.pix_data !== '0) begin bad++; $display("FAIL async_rst_pix got=%0d exp=0", bus.pix_data); end
    tick();
    total++;
    if (bus.cam_ack !== 1'b0) begin bad++; $display("FAIL async_rst_no_ack got=%0d exp=0", bus.cam_ack); end
    bus.cam_req = 1'b0;
    bus.pix_read = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.pix_read = 1'b0;
    bus.cam_req = 1'b0;
    bus.cam_addr = '0;
    bus.cam_data = '0;
    test_reset();
    test_fill();
    test_stream();
    test_cam();
    test_underflow();
    test_flush_inflight();
    test_done_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
